// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register-file slave: NUM_REGS byte-strobed registers exported flat on REGS_OUT.
// Optional macro AXIL_RO_ID_REG_EN turns register 0 into a read-only ID constant.
module axi_lite_regfile_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   input  logic                           AWVALID,
   input  logic [ADDR_WIDTH-1:0]          AWADDR,
   input  logic [2:0]                     AWPROT,
   output logic                           AWREADY,
   input  logic                           WVALID,
   input  logic [DATA_WIDTH-1:0]          WDATA,
   input  logic [DATA_WIDTH/8-1:0]        WSTRB,
   output logic                           WREADY,
   output logic                           BVALID,
   output logic [1:0]                     BRESP,
   input  logic                           BREADY,
   input  logic                           ARVALID,
   input  logic [ADDR_WIDTH-1:0]          ARADDR,
   input  logic [2:0]                     ARPROT,
   output logic                           ARREADY,
   output logic                           RVALID,
   output logic [DATA_WIDTH-1:0]          RDATA,
   output logic [1:0]                     RRESP,
   input  logic                           RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = $clog2(NUM_REGS);
   localparam int ADDR_HI  = ADDR_LSB + IDX_W;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_RO_ID_REG_EN
   localparam logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(32'hA11E_0001);
`endif

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                  aw_held, w_held, bvalid_q;
   logic [1:0]            bresp_q;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;

   logic                  rvalid_q;
   logic [1:0]            rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   logic unused_prot;
   assign unused_prot = ^{AWPROT, ARPROT};

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] upper;
      upper = addr >> ADDR_HI;
      return upper == '0;
   endfunction

   function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_LSB +: IDX_W];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_word,
                                                         input logic [DATA_WIDTH-1:0] new_word,
                                                         input logic [STRB_W-1:0]     strb);
      logic [DATA_WIDTH-1:0] result;
      result = old_word;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) result[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return result;
   endfunction

   // Readies depend only on registered state (and reset), never on the VALID inputs.
   assign AWREADY = !ARESET && !aw_held && !bvalid_q;
   assign WREADY  = !ARESET && !w_held  && !bvalid_q;
   assign ARREADY = !ARESET && !rvalid_q;

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID  && WREADY;
   assign ar_hs = ARVALID && ARREADY;

   // Commit on the edge where the second half of the AW/W pair arrives, so latency is one cycle.
   assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid_q;
   assign wr_addr = aw_held ? aw_addr_q : AWADDR;
   assign wr_data = w_held  ? w_data_q  : WDATA;
   assign wr_strb = w_held  ? w_strb_q  : WSTRB;
   assign wr_idx  = reg_index(wr_addr);
   assign rd_idx  = reg_index(ARADDR);

`ifdef AXIL_RO_ID_REG_EN
   assign wr_ok = in_range(wr_addr) && (wr_idx != '0);
`else
   assign wr_ok = in_range(wr_addr);
`endif

   always_comb begin
      rd_word = regs[rd_idx];
`ifdef AXIL_RO_ID_REG_EN
      if (rd_idx == '0) rd_word = ID_VALUE;
`endif
      if (!in_range(ARADDR)) rd_word = '0;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else if (commit && wr_ok) begin
         regs[wr_idx] <= merge_bytes(regs[wr_idx], wr_data, wr_strb);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         if (aw_hs) aw_held <= 1'b1;
         if (w_hs)  w_held  <= 1'b1;
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (bvalid_q && BREADY) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (aw_hs) aw_addr_q <= AWADDR;
      if (w_hs) begin
         w_data_q <= WDATA;
         w_strb_q <= WSTRB;
      end
   end

   // Read path: the captured word is the pre-edge register value, so a same-edge write is not seen.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_word;
         rresp_q  <= in_range(ARADDR) ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   assign BVALID = bvalid_q;
   assign BRESP  = bresp_q;
   assign RVALID = rvalid_q;
   assign RDATA  = rdata_q;
   assign RRESP  = rresp_q;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
`ifdef AXIL_RO_ID_REG_EN
      if (k == 0) begin : g_id
         assign REGS_OUT[k*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
      end else begin : g_rw
         assign REGS_OUT[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
      end
`else
      assign REGS_OUT[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
`endif
   end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed self-checking bench for axi_lite_regfile_slave (32-bit data, 16 registers).
module tb_axi_lite_regfile_slave;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 16;
`ifdef AXIL_RO_ID_REG_EN
   localparam logic [31:0] ID0 = 32'hA11E_0001;
`else
   localparam logic [31:0] ID0 = 32'h0;
`endif

   logic           ACLK = 1'b0;
   logic           ARESET;
   logic           AWVALID, WVALID, BREADY, ARVALID, RREADY;
   logic [AW-1:0]  AWADDR, ARADDR;
   logic [2:0]     AWPROT, ARPROT;
   logic [DW-1:0]  WDATA;
   logic [DW/8-1:0] WSTRB;
   logic           AWREADY, WREADY, BVALID, ARREADY, RVALID;
   logic [1:0]     BRESP, RRESP;
   logic [DW-1:0]  RDATA;
   logic [NR*DW-1:0] REGS_OUT;

   int checks = 0;
   int errors = 0;
   logic [31:0] d;
   logic [1:0]  r;

   axi_lite_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(AWPROT), .AWREADY(AWREADY),
      .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
      .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
      .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARREADY(ARREADY),
      .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
      .REGS_OUT(REGS_OUT)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] reg_out(input int k);
      return REGS_OUT[k*DW +: DW];
   endfunction

   // Called and returns at a negedge.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      int n = 0;
      logic aw_hs, w_hs;
      AWADDR = addr; WDATA = data; WSTRB = strb;
      AWVALID = 1'b1; WVALID = 1'b1;
      while ((AWVALID || WVALID) && n < 20) begin
         aw_hs = AWVALID && AWREADY;
         w_hs  = WVALID && WREADY;
         @(negedge ACLK);
         if (aw_hs) AWVALID = 1'b0;
         if (w_hs)  WVALID  = 1'b0;
         n++;
      end
      n = 0;
      while (!BVALID && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      check("wr_bvalid", BVALID, 1);
      resp = BRESP;
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      logic hs;
      ARADDR = addr; ARVALID = 1'b1;
      while (ARVALID && n < 20) begin
         hs = ARREADY;
         @(negedge ACLK);
         if (hs) ARVALID = 1'b0;
         n++;
      end
      check("rd_rvalid", RVALID, 1);
      data = RDATA; resp = RRESP;
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0; ARVALID = 1'b0;
   endtask

   initial begin
      ARESET = 1'b1;
      AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
      AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0; AWPROT = 3'b000; ARPROT = 3'b000;

      // Reset state
      repeat (3) @(negedge ACLK);
      check("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
      check("rst_bvalid", BVALID, 0);
      check("rst_rvalid", RVALID, 0);
      check("rst_rdata_resp", {RDATA, RRESP, BRESP}, 36'h0);
      check("rst_regs_zero", REGS_OUT[NR*DW-1:DW] == '0, 1);
      check("rst_reg0", reg_out(0), ID0);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("idle_readies", {AWREADY, WREADY, ARREADY}, 3'b111);

      // Same-cycle AW+W, one-cycle latency
      AWADDR = 32'h08; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0;
      check("sc_bvalid", BVALID, 1);
      check("sc_bresp", BRESP, 2'b00);
      check("sc_reg2", reg_out(2), 32'hDEAD_BEEF);
      check("sc_aw_w_ready_low", {AWREADY, WREADY}, 2'b00);
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      check("sc_bdone", BVALID, 0);
      check("sc_ready_again", {AWREADY, WREADY}, 2'b11);
      do_read(32'h08, d, r);
      check("sc_rdata", d, 32'hDEAD_BEEF);
      check("sc_rresp", r, 2'b00);

      // W two cycles before AW, byte strobes
      do_write(32'h04, 32'hFFFF_FFFF, 4'hF, r);
      check("wa_pre_resp", r, 2'b00);
      WDATA = 32'h1234_5678; WSTRB = 4'b0101; WVALID = 1'b1;
      @(negedge ACLK);
      WVALID = 1'b0;
      check("wa_wready_low", WREADY, 0);
      check("wa_no_b", BVALID, 0);
      @(negedge ACLK);
      check("wa_still_no_b", BVALID, 0);
      AWADDR = 32'h04; AWVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0;
      check("wa_bvalid", BVALID, 1);
      check("wa_bresp", BRESP, 2'b00);
      check("wa_reg1", reg_out(1), 32'hFF34_FF78);
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      repeat (3) @(negedge ACLK);
      check("wa_single_b", BVALID, 0);

      // Out of range, last in-range word, unaligned, zero strobe
      do_write(32'h40, 32'h0BAD_F00D, 4'hF, r);
      check("oor_bresp", r, 2'b10);
      check("oor_reg1", reg_out(1), 32'hFF34_FF78);
      check("oor_reg2", reg_out(2), 32'hDEAD_BEEF);
      check("oor_reg0", reg_out(0), ID0);
      do_read(32'h40, d, r);
      check("oor_rdata", d, 32'h0);
      check("oor_rresp", r, 2'b10);
      do_write(32'h3C, 32'h0F0F_0F0F, 4'hF, r);
      check("last_bresp", r, 2'b00);
      check("last_reg15", reg_out(15), 32'h0F0F_0F0F);
      do_read(32'h0B, d, r);
      check("unaligned_rdata", d, 32'hDEAD_BEEF);
      do_write(32'h08, 32'h0000_0000, 4'h0, r);
      check("zstrb_bresp", r, 2'b00);
      check("zstrb_reg2", reg_out(2), 32'hDEAD_BEEF);

      // Backpressure on B and R
      AWADDR = 32'h0C; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 32'h08; ARVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_b", {BVALID, BRESP}, 3'b100);
         check("bp_r", {RVALID, RDATA, RRESP}, {1'b1, 32'hDEAD_BEEF, 2'b00});
         check("bp_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
         @(negedge ACLK);
      end
      BREADY = 1'b1; RREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0; RREADY = 1'b0;
      check("bp_released", {BVALID, RVALID}, 2'b00);
      check("bp_readies_back", {AWREADY, WREADY, ARREADY}, 3'b111);
      check("bp_reg3", reg_out(3), 32'hCAFE_F00D);

      // Write and read of the same register at the same edge
      AWADDR = 32'h08; WDATA = 32'h1111_1111; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      ARADDR = 32'h08; ARVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      check("cc_rdata_old", RDATA, 32'hDEAD_BEEF);
      check("cc_reg2_new", reg_out(2), 32'h1111_1111);
      BREADY = 1'b1; RREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0; RREADY = 1'b0;

      // Register 0
`ifdef AXIL_RO_ID_REG_EN
      do_read(32'h00, d, r);
      check("id_rdata", d, 32'hA11E_0001);
      check("id_rresp", r, 2'b00);
      do_write(32'h00, 32'h1234_5678, 4'hF, r);
      check("id_wr_bresp", r, 2'b10);
      check("id_regs_out", reg_out(0), 32'hA11E_0001);
      do_read(32'h00, d, r);
      check("id_rdata_after", d, 32'hA11E_0001);
`else
      do_write(32'h00, 32'hA5A5_A5A5, 4'hF, r);
      check("r0_bresp", r, 2'b00);
      check("r0_regs_out", reg_out(0), 32'hA5A5_A5A5);
      do_read(32'h00, d, r);
      check("r0_rdata", d, 32'hA5A5_A5A5);
`endif

      // Reset between AW and W
      AWADDR = 32'h10; AWVALID = 1'b1;
      @(negedge ACLK);
      AWVALID = 1'b0;
      check("rm_aw_taken", AWREADY, 0);
      ARESET = 1'b1;
      @(negedge ACLK);
      check("rm_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rm_no_b", BVALID, 0);
      check("rm_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
      check("rm_regs_zero", REGS_OUT[NR*DW-1:DW] == '0, 1);
      check("rm_reg0", reg_out(0), ID0);
      do_read(32'h08, d, r);
      check("rm_rd8", d, 32'h0);
      do_read(32'h10, d, r);
      check("rm_rd10", d, 32'h0);
      do_write(32'h10, 32'h0000_0077, 4'hF, r);
      check("rm_recover_bresp", r, 2'b00);
      check("rm_recover_reg4", reg_out(4), 32'h0000_0077);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
